// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue ALU sequencer with register file (IDLE->READ->EXEC->WB).
// Optional op-code legality check enabled by defining ALU_ISSUE_OPCHECK_EN.
module alu_issue #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_r0,
  input  logic [AW-1:0] instr_r1,
  input  logic [AW-1:0] instr_rd,
  output logic [DW-1:0] alu_d0,
  output logic [DW-1:0] alu_d1,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_dout,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [DW-1:0] host_wdata,
  input  logic [AW-1:0] host_raddr,
  output logic [DW-1:0] host_rdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_op;
  logic [AW-1:0] r_r0;
  logic [AW-1:0] r_r1;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic [3:0]    r_alu_op;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_rf [NREG];
  logic          w_accept;
  logic          w_illegal;
  logic          w_wb_we;

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_READ;
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  assign w_accept = (r_state == S_IDLE) && instr_valid;

`ifdef ALU_ISSUE_OPCHECK_EN
  always_comb begin
    w_illegal = 1'b0;
    case (r_op)
      4'h3, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF: w_illegal = 1'b1;
      default: w_illegal = 1'b0;
    endcase
  end
  assign err = done && w_illegal;
`else
  assign w_illegal = 1'b0;
  assign err       = 1'b0;
`endif

  assign w_wb_we = (r_state == S_WB) && !w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
      r_r0 <= '0;
      r_r1 <= '0;
      r_rd <= '0;
    end else if (w_accept) begin
      r_op <= instr_op;
      r_r0 <= instr_r0;
      r_r1 <= instr_r1;
      r_rd <= instr_rd;
    end
  end

  // Operands only change in READ, so they hold through EXEC and stay put while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d0     <= '0;
      r_d1     <= '0;
      r_alu_op <= '0;
    end else if (r_state == S_READ) begin
      r_d0     <= r_rf[r_r0];
      r_d1     <= r_rf[r_r1];
      r_alu_op <= r_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                  r_result <= '0;
    else if (r_state == S_EXEC) r_result <= alu_dout;
  end

  // Writeback is assigned after the host write so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      if (host_we) r_rf[host_waddr] <= host_wdata;
      if (w_wb_we) r_rf[r_rd] <= r_result;
    end
  end

  assign alu_d0     = r_d0;
  assign alu_d1     = r_d1;
  assign alu_op     = r_alu_op;
  assign host_rdata = r_rf[host_raddr];
  assign busy       = (r_state != S_IDLE);

endmodule
